aes_128_arbiter: RTL and testbench
==================================

AES_128_ARBITER -- requirements
Module: aes_128_arbiter

Interface
REQ-001 SHALL have clk, input, 1: clock; all state on rising edge.
REQ-002 SHALL have reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have reqN_valid, input, 1 (N=0,1): requester N offers a job.
REQ-004 SHALL have reqN_ready, output, 1: job accepted when reqN_valid and reqN_ready are both high in the same cycle.
REQ-005 SHALL have reqN_encdec, input, 1: 1 = encipher, 0 = decipher.
REQ-006 SHALL have reqN_key, input, 128: AES-128 key.
REQ-007 SHALL have reqN_block, input, 128: input block.
REQ-008 SHALL have rspN_valid, output, 1: result pending for requester N.
REQ-009 SHALL have rspN_ready, input, 1: result consumed when rspN_valid and rspN_ready are both high.
REQ-010 SHALL have rspN_data, output, 128: result block.
REQ-011 SHALL have core_encdec, core_init, core_next, outputs, 1 each: core controls.
REQ-012 SHALL have core_key and core_block, outputs, 128 each: core operands.
REQ-013 SHALL have core_ready, core_result_valid, inputs, 1 each; core_result, input, 128: core status and result.

Function
REQ-014 SHALL implement FSM states IDLE, INIT, INIT_WAIT, NEXT, NEXT_WAIT.
REQ-015 SHALL raise reqN_ready only in IDLE, only with core_ready=1, only while rspN_valid=0, and only for the granted port; the accept is combinational from the grant.
REQ-016 SHALL arbitrate round-robin: on simultaneous eligible requests, grant the port not granted last; last_grant resets to 1, so port 0 wins the first tie.
REQ-017 SHALL register encdec, key, block and owner on accept.
REQ-018 SHALL drive core_encdec, core_key and core_block from those registers, held stable until return to IDLE.
REQ-019 On accept, SHALL go to INIT, or to NEXT on a key-cache hit (REQ-031).
REQ-020 SHALL assert core_init for exactly one cycle in INIT, then go to INIT_WAIT.
REQ-021 In INIT_WAIT, SHALL wait for core_ready=1, then load the cached key and set cache_valid=1.
REQ-022 SHALL assert core_next for exactly one cycle in NEXT, then go to NEXT_WAIT.
REQ-023 In NEXT_WAIT, when core_ready=1 and core_result_valid=1, SHALL capture core_result into the owner's response register, set rsp<owner>_valid, and return to IDLE.
REQ-024 SHALL hold rspN_valid and rspN_data stable until the handshake; the two response registers are independent.
REQ-025 SHALL never assert core_init and core_next together, and SHALL never pulse either while core_ready=0.
REQ-026 SHALL defer the job and keep its registers if a response handshake and a new accept occur for the same port in one cycle is impossible (REQ-015 blocks it); a handshake and an accept on different ports in one cycle are both honoured.
REQ-027 Latency: a cache-hit job SHALL show rspN_valid on the cycle after the core completes; NEXT adds exactly one cycle.

Reset
REQ-028 While reset_n=0, SHALL force: state IDLE; reqN_ready=0; rspN_valid=0; rspN_data=0; core_init=0; core_next=0; core_encdec=0; core_key=0; core_block=0; cache_valid=0; last_grant=1.
REQ-029 Reset mid-job SHALL drop the job silently and flush the cache.
REQ-030 The first job after reset SHALL always take the INIT path.

Configuration
REQ-031 With AES_ARB_KEY_CACHE_EN defined, SHALL skip INIT when cache_valid=1 and the accepted key equals the cached key; encdec does not affect a hit.
REQ-032 Without AES_ARB_KEY_CACHE_EN, SHALL have no cache registers or comparator, and every job SHALL take the INIT path.

Verification
REQ-033 Port 0 encipher, key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> rsp0_data 69c4e0d86a7b0430d8cdb78070b4c55a; one core_init pulse, one core_next pulse.
REQ-034 Port 1 decipher, same key, block 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp1_data 00112233445566778899aabbccddeeff; with cache enabled, zero core_init pulses; with it disabled, one pulse.
REQ-035 Both ports valid in the same cycle after reset, for 4 jobs each -> grants alternate 0,1,0,1,...; all 8 results correct.
REQ-036 rsp0_ready held low for 50 cycles -> rsp0 data stable throughout; port 0 not accepted again; port 1 jobs still complete.
REQ-037 Key change between jobs (2b7e151628aed2a6abf7158809cf4f3c, block 6bc1bee22e409f96e93d7e117393172a) -> init pulse issued; result 3ad77bb40d7a3660a89ecaf32466ef97.
REQ-038 reset_n pulsed low during NEXT_WAIT -> all outputs at reset values; the next identical job re-inits and completes correctly.

Source files
------------

// File: rtl/aes_128_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_128_arbiter
// Description : Two-port round-robin front end sharing one AES-128 core.
//               Optional key cache enabled by defining AES_ARB_KEY_CACHE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module aes_128_arbiter (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_encdec,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_block,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_data,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_encdec,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_block,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_data,

    output logic         core_encdec,
    output logic         core_init,
    output logic         core_next,
    output logic [127:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic         core_result_valid,
    input  logic [127:0] core_result
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_NEXT      = 3'd3,
        ST_NEXT_WAIT = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic         r_last_grant;
    logic         r_owner;
    logic         r_encdec;
    logic [127:0] r_key;
    logic [127:0] r_block;
    logic         r_rsp0_valid;
    logic         r_rsp1_valid;
    logic [127:0] r_rsp0_data;
    logic [127:0] r_rsp1_data;

    logic         w_elig0;
    logic         w_elig1;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_arb_open;
    logic         w_accept;
    logic         w_done;
    logic         w_cache_hit;
    logic         w_acc_encdec;
    logic [127:0] w_acc_key;
    logic [127:0] w_acc_block;

    // A port with an unconsumed response is not offered a new job.
    assign w_elig0    = req0_valid & ~r_rsp0_valid;
    assign w_elig1    = req1_valid & ~r_rsp1_valid;
    assign w_gnt1     = w_elig1 & (~w_elig0 | ~r_last_grant);
    assign w_gnt0     = w_elig0 & ~w_gnt1;
    assign w_arb_open = reset_n & (r_state == ST_IDLE) & core_ready;

    assign req0_ready = w_arb_open & w_gnt0;
    assign req1_ready = w_arb_open & w_gnt1;
    assign w_accept   = w_arb_open & (w_gnt0 | w_gnt1);
    assign w_done     = (r_state == ST_NEXT_WAIT) & core_ready & core_result_valid;

    assign w_acc_encdec = w_gnt1 ? req1_encdec : req0_encdec;
    assign w_acc_key    = w_gnt1 ? req1_key    : req0_key;
    assign w_acc_block  = w_gnt1 ? req1_block  : req0_block;

`ifdef AES_ARB_KEY_CACHE_EN
    logic [127:0] r_cache_key;
    logic         r_cache_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_key   <= '0;
            r_cache_valid <= 1'b0;
        end else if ((r_state == ST_INIT_WAIT) && core_ready) begin
            r_cache_key   <= r_key;
            r_cache_valid <= 1'b1;
        end
    end

    // Key schedule is direction independent, so encdec plays no part in a hit.
    assign w_cache_hit = r_cache_valid & (w_acc_key == r_cache_key);
`else
    assign w_cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Core strobes are only issued while the core reports ready.
    always_comb begin
        w_state_nxt = r_state;
        core_init   = 1'b0;
        core_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_cache_hit ? ST_NEXT : ST_INIT;
                end
            end
            ST_INIT: begin
                if (core_ready) begin
                    core_init   = 1'b1;
                    w_state_nxt = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (core_ready) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (core_ready) begin
                    core_next   = 1'b1;
                    w_state_nxt = ST_NEXT_WAIT;
                end
            end
            ST_NEXT_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_encdec     <= 1'b0;
            r_key        <= '0;
            r_block      <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_gnt1;
                r_last_grant <= w_gnt1;
                r_encdec     <= w_acc_encdec;
                r_key        <= w_acc_key;
                r_block      <= w_acc_block;
            end
            if (r_rsp0_valid && rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end
            if (r_rsp1_valid && rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end
            // The owner's response slot is empty here, so no clash with its handshake.
            if (w_done) begin
                if (r_owner) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_data  <= core_result;
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_data  <= core_result;
                end
            end
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_data   = r_rsp0_data;
    assign rsp1_data   = r_rsp1_data;
    assign core_encdec = r_encdec;
    assign core_key    = r_key;
    assign core_block  = r_block;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_arbiter
// Description : Directed bench for aes_128_arbiter with a behavioural core.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_128_arbiter;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [1:0]   req_encdec = 2'b00;
    logic [127:0] req_key [2];
    logic [127:0] req_block [2];
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b00;
    logic [127:0] rsp_data [2];
    logic         core_encdec, core_init, core_next;
    logic         core_ready, core_result_valid;
    logic [127:0] core_key, core_block, core_result;

    int checks = 0;
    int errors = 0;
    int init_cnt = 0, next_cnt = 0, viol = 0, cyc = 0, done_cyc = 0;

    aes_128_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_encdec(req_encdec[0]),
        .req0_key(req_key[0]), .req0_block(req_block[0]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp_data[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_encdec(req_encdec[1]),
        .req1_key(req_key[1]), .req1_block(req_block[1]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp_data[1]),
        .core_encdec(core_encdec), .core_init(core_init), .core_next(core_next),
        .core_key(core_key), .core_block(core_block),
        .core_ready(core_ready), .core_result_valid(core_result_valid), .core_result(core_result)
    );

    always #5 clk = ~clk;

    // Behavioural AES core: known-answer table, busy for a few cycles per strobe.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] b, input logic ed);
        if (ed && k == K1 && b == P1) return C1;
        if (!ed && k == K1 && b == C1) return P1;
        if (ed && k == K2 && b == P2) return C2;
        if (!ed && k == K2 && b == C2) return P2;
        return {4{32'hdeadbeef}};
    endfunction

    logic [127:0] m_key, m_blk;
    logic         m_ed, m_is_next;
    int           m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready        <= 1'b1;
            core_result_valid <= 1'b0;
            core_result       <= '0;
            m_key             <= '0;
            m_blk             <= '0;
            m_ed              <= 1'b0;
            m_is_next         <= 1'b0;
            m_cnt             <= 0;
        end else begin
            cyc <= cyc + 1;
            if ((core_init && core_next) || ((core_init || core_next) && !core_ready))
                viol <= viol + 1;
            if (core_init) begin
                init_cnt   <= init_cnt + 1;
                core_ready <= 1'b0;
                m_key      <= core_key;
                m_is_next  <= 1'b0;
                m_cnt      <= 3;
            end else if (core_next) begin
                next_cnt          <= next_cnt + 1;
                core_ready        <= 1'b0;
                core_result_valid <= 1'b0;
                m_blk             <= core_block;
                m_ed              <= core_encdec;
                m_is_next         <= 1'b1;
                m_cnt             <= 4;
            end else if (!core_ready) begin
                if (m_cnt <= 1) begin
                    core_ready <= 1'b1;
                    if (m_is_next) begin
                        core_result_valid <= 1'b1;
                        core_result       <= aes_ref(m_key, m_blk, m_ed);
                        done_cyc          <= cyc + 1;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    bit           mon_en = 1'b0;
    int           mon_bad = 0, mon_acc0 = 0;
    logic [127:0] mon_data = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rsp_valid[0] || rsp_data[0] !== mon_data) mon_bad <= mon_bad + 1;
            if (req_valid[0] && req_ready[0]) mon_acc0 <= mon_acc0 + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input int p, input logic ed, input logic [127:0] k, input logic [127:0] b);
        req_valid[p]  = 1'b1;
        req_encdec[p] = ed;
        req_key[p]    = k;
        req_block[p]  = b;
    endtask

    task automatic wait_accept(input int p, input string tag);
        int n = 0;
        @(negedge clk);
        while (!req_ready[p] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, 128'(n < 200), 128'(1));
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int p, input logic [127:0] exp, input string tag, input bit chk_lat);
        int n = 0;
        while (!rsp_valid[p] && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_rsp_timeout"}, 128'(n < 300), 128'(1));
        if (chk_lat) chk({tag, "_latency"}, 128'(cyc), 128'(done_cyc + 1));
        chk({tag, "_data"}, rsp_data[p], exp);
        rsp_ready[p] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[p] = 1'b0;
        chk({tag, "_valid_cleared"}, 128'(rsp_valid[p]), 128'(0));
    endtask

    function automatic int jidx(input int p, input int k);
        return (p == 0) ? k : 3 - k;
    endfunction

    logic         jed [4];
    logic [127:0] jk [4], jb [4], je [4];
    int           jn [2], rn [2];
    bit           acc [2];
    int           gcount, guard, i0, n0, t0, wn;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        jed[0] = 1'b1; jk[0] = K1; jb[0] = P1; je[0] = C1;
        jed[1] = 1'b1; jk[1] = K2; jb[1] = P2; je[1] = C2;
        jed[2] = 1'b0; jk[2] = K1; jb[2] = C1; je[2] = P1;
        jed[3] = 1'b0; jk[3] = K2; jb[3] = C2; je[3] = P2;
        req_key[0] = '0; req_key[1] = '0; req_block[0] = '0; req_block[1] = '0;

        // Reset values, with requests asserted to prove ready stays low.
        reset_n = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp0_data", rsp_data[0], 128'(0));
        chk("rst_rsp1_data", rsp_data[1], 128'(0));
        chk("rst_core_ctl", 128'({core_encdec, core_init, core_next}), 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_core_block", core_block, 128'(0));
        req_valid = 2'b00;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 encipher on port 0: full INIT path.
        i0 = init_cnt; n0 = next_cnt;
        start_req(0, 1'b1, K1, P1);
        wait_accept(0, "enc0");
        wait_rsp(0, C1, "enc0", 1'b1);
        chk("enc0_init_pulses", 128'(init_cnt - i0), 128'(1));
        chk("enc0_next_pulses", 128'(next_cnt - n0), 128'(1));

        // Same key deciphered on port 1: cache hit when the cache is built in.
        i0 = init_cnt; n0 = next_cnt;
        start_req(1, 1'b0, K1, C1);
        wait_accept(1, "dec1");
        wait_rsp(1, P1, "dec1", 1'b1);
`ifdef AES_ARB_KEY_CACHE_EN
        chk("dec1_init_pulses", 128'(init_cnt - i0), 128'(0));
`else
        chk("dec1_init_pulses", 128'(init_cnt - i0), 128'(1));
`endif
        chk("dec1_next_pulses", 128'(next_cnt - n0), 128'(1));

        // New key forces a fresh key expansion.
        i0 = init_cnt;
        start_req(0, 1'b1, K2, P2);
        wait_accept(0, "keychg");
        wait_rsp(0, C2, "keychg", 1'b1);
        chk("keychg_init_pulses", 128'(init_cnt - i0), 128'(1));

        // Fresh reset, then both ports contend for four jobs each.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        jn[0] = 0; jn[1] = 0; rn[0] = 0; rn[1] = 0; gcount = 0; guard = 0;
        rsp_ready = 2'b11;
        for (int p = 0; p < 2; p++) start_req(p, jed[jidx(p, 0)], jk[jidx(p, 0)], jb[jidx(p, 0)]);
        while ((rn[0] < 4 || rn[1] < 4) && guard < 3000) begin
            @(negedge clk);
            guard++;
            for (int p = 0; p < 2; p++) begin
                acc[p] = req_valid[p] & req_ready[p];
                if (rsp_valid[p]) begin
                    chk($sformatf("tie_rsp%0d_%0d", p, rn[p]), rsp_data[p], je[jidx(p, rn[p] & 3)]);
                    rn[p]++;
                end
                if (acc[p]) begin
                    chk($sformatf("tie_grant_%0d", gcount), 128'(p), 128'(gcount % 2));
                    gcount++;
                    jn[p]++;
                end
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    if (jn[p] < 4) start_req(p, jed[jidx(p, jn[p])], jk[jidx(p, jn[p])], jb[jidx(p, jn[p])]);
                    else req_valid[p] = 1'b0;
                end
            end
        end
        chk("tie_timeout", 128'(guard < 3000), 128'(1));
        chk("tie_grant_count", 128'(gcount), 128'(8));
        rsp_ready = 2'b00;
        req_valid = 2'b00;

        // Port 0 response held unconsumed for 50 cycles while port 1 keeps working.
        start_req(0, 1'b1, K2, P2);
        wait_accept(0, "hold_a");
        wn = 0;
        while (!rsp_valid[0] && wn < 300) begin
            @(posedge clk);
            #1;
            wn++;
        end
        chk("hold_a_rsp_timeout", 128'(wn < 300), 128'(1));
        chk("hold_a_data", rsp_data[0], C2);
        mon_data = C2;
        t0 = cyc;
        mon_en = 1'b1;
        start_req(0, 1'b0, K2, C2);
        start_req(1, 1'b0, K1, C1);
        wait_accept(1, "hold_p1a");
        wait_rsp(1, P1, "hold_p1a", 1'b1);
        start_req(1, 1'b1, K1, P1);
        wait_accept(1, "hold_p1b");
        wait_rsp(1, C1, "hold_p1b", 1'b1);
        while (cyc < t0 + 50) @(posedge clk);
        #1;
        mon_en = 1'b0;
        #1;
        chk("hold_rsp0_unstable_cycles", 128'(mon_bad), 128'(0));
        chk("hold_port0_accepts", 128'(mon_acc0), 128'(0));
        wait_rsp(0, C2, "hold_release", 1'b0);
        wait_accept(0, "hold_b");
        wait_rsp(0, P2, "hold_b", 1'b1);

        // Reset asserted while the core is computing the block.
        start_req(0, 1'b1, K1, P1);
        wait_accept(0, "midrst_a");
        wn = 0;
        @(negedge clk);
        while (!core_next && wn < 200) begin
            @(negedge clk);
            wn++;
        end
        chk("midrst_next_seen", 128'(wn < 200), 128'(1));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("midrst_req_ready", 128'(req_ready), 128'(0));
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("midrst_rsp0_data", rsp_data[0], 128'(0));
        chk("midrst_rsp1_data", rsp_data[1], 128'(0));
        chk("midrst_core_ctl", 128'({core_encdec, core_init, core_next}), 128'(0));
        chk("midrst_core_key", core_key, 128'(0));
        chk("midrst_core_block", core_block, 128'(0));
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        i0 = init_cnt;
        start_req(0, 1'b1, K1, P1);
        wait_accept(0, "midrst_b");
        wait_rsp(0, C1, "midrst_b", 1'b1);
        chk("midrst_b_init_pulses", 128'(init_cnt - i0), 128'(1));

        chk("core_strobe_violations", 128'(viol), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
